// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshaking.
// One producer stream is steered by in_control (0 -> port 1, 1 -> port 2)
// into a one-entry output slot per port. Each port counts its deliveries
// with a saturating counter.
//
// Slot FSM states:
//   state | meaning
//   EMPTY | slot holds no word, outN_valid = 0
//   FULL  | slot holds a word,  outN_valid = 1

module demux_1to2_slot #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    input  logic             clr_cnt,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt,
    output logic             accept_ok
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    slot_state_t state_q;
    slot_state_t state_d;
    logic        drain;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // State register; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: load fills, drain without load empties, otherwise hold.
    // A load is only ever offered when the slot is empty or draining.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (drain && !load) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Outputs: valid mirrors FULL; the slot can take a word when empty
    // or when its current word leaves this cycle.
    always_comb begin
        valid     = (state_q == FULL);
        drain     = (state_q == FULL) && ready;
        accept_ok = (state_q == EMPTY) || ready;
    end

    // Data register only changes on load, so it stays stable under stall
    // and keeps its last value after a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    // Delivery counter: clear beats a simultaneous drain, saturates at max.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (drain && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

module demux_1to2_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_control,
    input  logic [WIDTH-1:0] in_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2
);

    logic accept1_ok;
    logic accept2_ok;
    logic load1;
    logic load2;

    // Ready follows only the selected slot (head-of-line blocking), never in_valid.
    always_comb begin
        in_ready = in_control ? accept2_ok : accept1_ok;
        load1    = in_valid && in_ready && !in_control;
        load2    = in_valid && in_ready &&  in_control;
    end

    demux_1to2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .clr_cnt   (clr_cnt),
        .valid     (out1_valid),
        .data      (out1_data),
        .cnt       (cnt1),
        .accept_ok (accept1_ok)
    );

    demux_1to2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load2),
        .load_data (in_data),
        .ready     (out2_ready),
        .clr_cnt   (clr_cnt),
        .valid     (out2_valid),
        .data      (out2_data),
        .cnt       (cnt2),
        .accept_ok (accept2_ok)
    );

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: directed scenarios plus random
// traffic, all compared each cycle against a queue-based reference model.

module tb_demux_1to2_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_control;
    logic [WIDTH-1:0] in_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [WIDTH-1:0] out2_data;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: one queue per port plus last-loaded word and counts
    logic [WIDTH-1:0] mq [2][$];
    logic [WIDTH-1:0] mlast [2];
    int               mcnt [2];

    demux_1to2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_control (in_control),
        .in_data    (in_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data),
        .clr_cnt    (clr_cnt),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            mq[p].delete();
            mlast[p] = '0;
            mcnt[p]  = 0;
        end
    endtask

    // One cycle: drive at negedge, check outputs against the model, advance model, take edge.
    task automatic step(input logic iv, input logic ctl, input logic [WIDTH-1:0] d,
                        input logic r1, input logic r2, input logic clr, input logic rst);
        logic rdy_exp;
        logic [1:0] rdy;
        logic [1:0] drain;
        int sel;
        @(negedge clk);
        in_valid = iv; in_control = ctl; in_data = d;
        out1_ready = r1; out2_ready = r2; clr_cnt = clr; rst_n = rst;
        #1;
        rdy = {r2, r1};
        sel = ctl ? 1 : 0;
        rdy_exp = (mq[sel].size() == 0) || rdy[sel];
        chk("in_ready",   {31'b0, in_ready},   {31'b0, rdy_exp});
        chk("out1_valid", {31'b0, out1_valid}, {31'b0, mq[0].size() != 0});
        chk("out2_valid", {31'b0, out2_valid}, {31'b0, mq[1].size() != 0});
        chk("out1_data",  out1_data, (mq[0].size() != 0) ? mq[0][0] : mlast[0]);
        chk("out2_data",  out2_data, (mq[1].size() != 0) ? mq[1][0] : mlast[1]);
        chk("cnt1", {29'b0, cnt1}, mcnt[0]);
        chk("cnt2", {29'b0, cnt2}, mcnt[1]);
        if (!rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < 2; p++) begin
                drain[p] = (mq[p].size() != 0) && rdy[p];
                if (drain[p]) void'(mq[p].pop_front());
                if (clr) mcnt[p] = 0;
                else if (drain[p] && mcnt[p] < CMAX) mcnt[p] = mcnt[p] + 1;
            end
            if (iv && rdy_exp) begin
                mq[sel].push_back(d);
                mlast[sel] = d;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic r1, input logic r2, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, r1, r2, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_control = 1'b0; in_data = '0;
        out1_ready = 1'b0; out2_ready = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        do_reset();

        // 1. basic routing
        step(1'b1, 1'b0, 32'hAAAA0001, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'hBBBB0002, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1'b1, 2);
        #1;
        chk("t1_cnt1", {29'b0, cnt1}, 32'd1);
        chk("t1_cnt2", {29'b0, cnt2}, 32'd1);

        // 2. backpressure and stability
        do_reset();
        step(1'b1, 1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        chk("t2_hold_data",  out1_data, 32'h12345678);
        chk("t2_hold_valid", {31'b0, out1_valid}, 32'd1);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("t2_second_word", out1_data, 32'hCAFEF00D);
        idle(1'b1, 1'b1, 2);

        // 3. streaming to port 2
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b1, 1'b1, 2);
        #1;
        chk("t3_cnt2_sat", {29'b0, cnt2}, CMAX);

        // 4. counter saturation and clear-vs-drain
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 32'h100 + i, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b0, 2);
        #1;
        chk("t4_cnt1_sat", {29'b0, cnt1}, 32'd7);
        step(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("t4_clr_wins", {29'b0, cnt1}, 32'd0);

        // 5. reset mid-operation
        step(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        #1;
        chk("t5_v1",   {31'b0, out1_valid}, 32'd0);
        chk("t5_v2",   {31'b0, out2_valid}, 32'd0);
        chk("t5_d1",   out1_data, 32'd0);
        chk("t5_d2",   out2_data, 32'd0);
        idle(1'b1, 1'b1, 3);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 127) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to2_reg.md
Name: demux_1to2_reg

Overview:
Registered 1-to-2 demultiplexer with valid/ready handshaking. It is the dispatch counterpart of the codebase's 2-to-1 select logic: one producer stream is steered to one of two consumer ports by a control bit. The polarity matches the mux: control 0 selects port 1, control 1 selects port 2. Each destination has a one-entry output register, so the block decouples producer and consumer timing in the datapath. Per-port delivery counters support debug and verification.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of each delivery counter.

Ports:
- clk, input, 1, rising-edge clock for all state.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, producer has a word to send.
- in_ready, output, 1, block accepts the word this cycle.
- in_control, input, 1, destination select: 0 = port 1, 1 = port 2.
- in_data, input, WIDTH, word to route.
- out1_valid, output, 1, port 1 slot holds a word.
- out1_ready, input, 1, port 1 consumer accepts.
- out1_data, output, WIDTH, port 1 word.
- out2_valid, output, 1, port 2 slot holds a word.
- out2_ready, input, 1, port 2 consumer accepts.
- out2_data, output, WIDTH, port 2 word.
- clr_cnt, input, 1, synchronous clear of both counters.
- cnt1, output, CNT_W, words delivered on port 1.
- cnt2, output, CNT_W, words delivered on port 2.

Behaviour:
Reset and state
- Single clock domain; reset is synchronous and active-low on rst_n, sampled at the clk rising edge.
- While rst_n = 0: out1_valid = out2_valid = 0, out1_data = out2_data = 0, cnt1 = cnt2 = 0.
- Asserting reset mid-operation discards any pending slot contents. No outputs pulse during or after reset.
- Each slot has a two-state FSM, EMPTY or FULL, exposed as outN_valid.

Handshake definitions
- Input handshake: in_valid && in_ready.
- Port N drain: outN_valid && outN_ready.

in_ready
- Combinational in in_control and registered state only. It never depends on in_valid.
- in_ready = selected slot EMPTY, or selected slot draining this cycle.

Slot transitions, port N (N = selected port, in_control 0 → 1, 1 → 2)
- EMPTY + input handshake targeting N → FULL, outN_data <= in_data. Latency is 1 cycle: valid appears the cycle after acceptance.
- FULL + drain, no load → EMPTY. outN_data holds its last value.
- FULL + drain + load in the same cycle → stays FULL with the new word. Full throughput is one word per cycle per port.
- FULL, no drain → hold. outN_data must stay stable while outN_valid && !outN_ready.

Other rules
- The non-selected slot is never affected by the input side and drains independently.
- Head-of-line blocking: if the selected slot is blocked, input stalls even if the other slot is empty. Ordering is preserved per port.

Counters
- cntN increments by 1 on each port N drain and saturates at 2^CNT_W−1 (no wrap).
- clr_cnt = 1 forces both counters to 0 next cycle. Clear wins over a simultaneous drain.

Test Plan:
1. Basic routing. Reset, then send 0xAAAA0001 with control=0 and 0xBBBB0002 with control=1, both consumers ready. Required: out1 shows 0xAAAA0001 one cycle after acceptance, then out2 shows 0xBBBB0002. cnt1 = 1, cnt2 = 1.
2. Backpressure and stability. With out1_ready = 0, send 0x12345678 to port 1, then offer a second word to port 1.
   - out1_data stays 0x12345678 and out1_valid stays 1.
   - in_ready = 0 for control = 0 while in_ready = 1 for control = 0→1 switch (port 2 empty).
   - Raise out1_ready: the second word is accepted in the same cycle as the drain.
3. Streaming. Route 8 back-to-back words 0..7 to port 2 with out2_ready = 1. Required: in_ready stays 1 throughout, out2 delivers 0..7 in order on consecutive cycles, cnt2 = 8.
4. Counter boundaries.
   - With CNT_W = 3, deliver 9 words to port 1: cnt1 saturates at 7.
   - Assert clr_cnt in the same cycle as a port 1 drain: cnt1 = 0.
5. Reset mid-operation. Fill both slots (both readies low) and pulse rst_n = 0 for one cycle. Required: both valids are 0 and both data outputs are 0 next cycle, counters are 0, and no stale word appears after reset releases.
